carregador_memoria: RTL and testbench
=====================================

CARREGADOR_MEMORIA -- requirements
Module: carregador_memoria

Interface
REQ-001 The block SHALL have parameter FILL_DEFAULT, default 2'b10, the value latched as fill data when modo=0 and usa_default=1.
REQ-002 The block SHALL have parameter N_POS, default 16, the number of words written per load; legal range 1..16.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 rising-edge clock, then rst_n input 1 async active-low reset.
REQ-004 The block SHALL have port iniciar, input, 1 bit: start pulse, sampled in IDLE only.
REQ-005 The block SHALL have port modo, input, 1 bit: 0 = constant fill, 1 = stream.
REQ-006 The block SHALL have port usa_default, input, 1 bit: in constant fill, 1 = use FILL_DEFAULT, 0 = use dado_fill.
REQ-007 The block SHALL have port dado_fill, input, 2 bits: constant fill value.
REQ-008 The block SHALL have ports dado_in (input, 2 bits) and valido_in (input, 1 bit): stream word and its valid flag.
REQ-009 The block SHALL have port pronto_in, output, 1 bit: stream ready.
REQ-010 The block SHALL have ports mem_we (output, 1 bit), mem_addr (output, 4 bits) and mem_data (output, 2 bits): memory write port.
REQ-011 The block SHALL have port mem_q, input, 2 bits: memory read data, valid one cycle after mem_addr is presented.
REQ-012 The block SHALL have status outputs ocupado (1 bit, high when not IDLE), fim (1 bit, one-cycle done pulse) and erro (1 bit, sticky readback mismatch).

Function
REQ-013 The FSM SHALL have states IDLE, ESCREVE, VERIFICA and FIM; VERIFICA exists only per REQ-028.
REQ-014 In IDLE, iniciar=1 SHALL latch modo, the fill value, clear erro, set mem_addr=0 and enter ESCREVE at the next edge.
REQ-015 iniciar SHALL be ignored outside IDLE.
REQ-016 In ESCREVE with modo=0, mem_we SHALL be 1 every cycle, and mem_addr SHALL step 0..N_POS-1, one word per cycle (N_POS cycles).
REQ-017 In ESCREVE with modo=1, pronto_in SHALL be 1, mem_we SHALL equal valido_in, mem_data SHALL equal dado_in, and mem_addr SHALL advance only on valido_in=1.
REQ-018 valido_in while pronto_in=0 SHALL be ignored.
REQ-019 Each word written SHALL be stored in a 16x2 shadow register indexed by address.
REQ-020 A write to address N_POS-1 SHALL exit ESCREVE at the next edge and wrap mem_addr to 0.
REQ-021 FIM SHALL last exactly one cycle, assert fim=1 and return to IDLE.
REQ-022 mem_we SHALL be 0 in every state other than ESCREVE.
REQ-023 mem_addr SHALL hold its last value in IDLE.
REQ-024 Address arithmetic SHALL be 4-bit unsigned with no value exceeding N_POS-1.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, mem_we=0, mem_addr=0, mem_data=0, pronto_in=0, ocupado=0, fim=0, erro=0 and the shadow register to 0.
REQ-026 A reset during ESCREVE or VERIFICA SHALL abandon the load; after release the block SHALL wait for a new iniciar.

Configuration
REQ-027 Readback verification SHALL be compiled in or out by macro CARREGADOR_VERIFICA_EN.
REQ-028 With CARREGADOR_VERIFICA_EN defined, ESCREVE SHALL exit to VERIFICA, which presents mem_addr 0..N_POS-1 in consecutive cycles.
REQ-029 In VERIFICA, each cycle after an address is presented, mem_q SHALL be compared with the shadow word; any mismatch SHALL set erro.
REQ-030 VERIFICA SHALL last N_POS+1 cycles and then enter FIM.
REQ-031 Without CARREGADOR_VERIFICA_EN, ESCREVE SHALL exit directly to FIM, erro SHALL be tied to 0 and mem_q SHALL be unused.

Verification
REQ-032 Constant fill: modo=0, usa_default=1, iniciar pulse -> 16 cycles of mem_we=1 at addresses 0..15 with mem_data=2'b10, then fim pulse; with the macro, fim arrives 17 cycles later with erro=0.
REQ-033 Stream with gaps: modo=1, valido_in toggling 1,0,1,... with dado_in=addr[1:0] -> exactly 16 writes with mem_data=addr[1:0], address unchanged on gap cycles.
REQ-034 Readback fault (macro on): memory model corrupts address 5 to 2'b01 on a fill of 2'b11 -> erro=1 at fim and held until the next iniciar.
REQ-035 Reset mid-load: rst_n low at address 7 -> mem_we=0 and ocupado=0 with no clock edge; after release, iniciar restarts the load at address 0.
REQ-036 Start while busy: iniciar pulsed at address 3 -> no restart, and the total write count remains 16.
REQ-037 N_POS=1: iniciar pulse -> a single write to address 0, then fim pulse.

Source files
------------

// File: rtl/carregador_memoria.sv
// carregador_memoria: loads N_POS words into a 16x2 memory, from a constant or a valid-qualified
// stream. Define CARREGADOR_VERIFICA_EN to compile in the readback pass that sets the sticky erro.
module carregador_memoria #(
   parameter logic [1:0]  FILL_DEFAULT = 2'b10,
   parameter int unsigned N_POS        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iniciar,
   input  logic       modo,
   input  logic       usa_default,
   input  logic [1:0] dado_fill,
   input  logic [1:0] dado_in,
   input  logic       valido_in,
   output logic       pronto_in,
   output logic       mem_we,
   output logic [3:0] mem_addr,
   output logic [1:0] mem_data,
   input  logic [1:0] mem_q,
   output logic       ocupado,
   output logic       fim,
   output logic       erro
);

   typedef enum logic [1:0] {StIdle, StEscreve, StVerifica, StFim} estado_e;

   localparam logic [3:0] UltimoEnd = 4'(N_POS - 1);

   estado_e          estado_q;
   logic             modo_q;
   logic [1:0]       fill_q;
   logic [3:0]       addr_q;
   logic [15:0][1:0] shadow_q;

`ifdef CARREGADOR_VERIFICA_EN
   logic       erro_q;
   logic       pend_q;      // a read issued last cycle is due for comparison now
   logic [3:0] chk_addr_q;
   logic       apres_fim_q; // every address has been presented
`endif

   // Stream handshake and write strobe follow valido_in within the cycle.
   always_comb begin
      pronto_in = (estado_q == StEscreve) && modo_q;
      mem_we    = (estado_q == StEscreve) && (!modo_q || valido_in);
      mem_data  = pronto_in ? dado_in : fill_q;
      ocupado   = (estado_q != StIdle);
      fim       = (estado_q == StFim);
   end

   assign mem_addr = addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= StIdle;
         modo_q      <= 1'b0;
         fill_q      <= 2'b00;
         addr_q      <= 4'd0;
         shadow_q    <= '0;
`ifdef CARREGADOR_VERIFICA_EN
         erro_q      <= 1'b0;
         pend_q      <= 1'b0;
         chk_addr_q  <= 4'd0;
         apres_fim_q <= 1'b0;
`endif
      end else begin
         case (estado_q)
            StIdle: begin
               if (iniciar) begin
                  modo_q   <= modo;
                  fill_q   <= (!modo && usa_default) ? FILL_DEFAULT : dado_fill;
                  addr_q   <= 4'd0;
                  estado_q <= StEscreve;
`ifdef CARREGADOR_VERIFICA_EN
                  erro_q   <= 1'b0;
`endif
               end
            end
            StEscreve: begin
               if (mem_we) begin
                  shadow_q[addr_q] <= mem_data;
                  if (addr_q == UltimoEnd) begin
                     addr_q <= 4'd0;
`ifdef CARREGADOR_VERIFICA_EN
                     pend_q      <= 1'b0;
                     apres_fim_q <= 1'b0;
                     estado_q    <= StVerifica;
`else
                     estado_q    <= StFim;
`endif
                  end else begin
                     addr_q <= addr_q + 4'd1;
                  end
               end
            end
            StVerifica: begin
`ifdef CARREGADOR_VERIFICA_EN
               if (pend_q && (mem_q != shadow_q[chk_addr_q])) begin
                  erro_q <= 1'b1;
               end
               if (apres_fim_q) begin
                  addr_q   <= 4'd0;
                  estado_q <= StFim;
               end else begin
                  pend_q     <= 1'b1;
                  chk_addr_q <= addr_q;
                  if (addr_q == UltimoEnd) begin
                     apres_fim_q <= 1'b1;
                  end else begin
                     addr_q <= addr_q + 4'd1;
                  end
               end
`else
               estado_q <= StIdle;
`endif
            end
            StFim: begin
               estado_q <= StIdle;
            end
            default: begin
               estado_q <= StIdle;
            end
         endcase
      end
   end

`ifdef CARREGADOR_VERIFICA_EN
   assign erro = erro_q;
`else
   // Without readback the shadow copy and mem_q have no consumer.
   logic unused_sinais;
   assign unused_sinais = ^{mem_q, shadow_q};
   assign erro          = 1'b0;
`endif

endmodule

// File: tb/tb_carregador_memoria.sv
// Self-checking bench for carregador_memoria: randomized loads against a write-sequence model.
module tb_carregador_memoria;

`ifdef CARREGADOR_VERIFICA_EN
   localparam bit VERIF = 1'b1;
`else
   localparam bit VERIF = 1'b0;
`endif
   localparam int         NP          = 16;
   localparam logic [1:0] FILL_PADRAO = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       iniciar = 1'b0, iniciar1 = 1'b0;
   logic       modo = 1'b0, usa_default = 1'b0, valido_in = 1'b0;
   logic [1:0] dado_fill = 2'b00, dado_in = 2'b00;
   logic       pronto_in, mem_we, ocupado, fim, erro;
   logic [3:0] mem_addr;
   logic [1:0] mem_data, mem_q;
   logic       pronto1, we1, ocup1, fim1, erro1;
   logic [3:0] addr1;
   logic [1:0] data1, mem_q1, mem1;

   int   vetores = 0;
   int   erros = 0;
   logic corrompe = 1'b0;
   logic erro_ant = 1'b0;
   logic [1:0] mem [16];

   always #5 clk = ~clk;

   carregador_memoria dut (
      .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .modo(modo), .usa_default(usa_default),
      .dado_fill(dado_fill), .dado_in(dado_in), .valido_in(valido_in), .pronto_in(pronto_in),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
      .ocupado(ocupado), .fim(fim), .erro(erro)
   );

   carregador_memoria #(.N_POS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .iniciar(iniciar1), .modo(modo), .usa_default(usa_default),
      .dado_fill(dado_fill), .dado_in(dado_in), .valido_in(valido_in), .pronto_in(pronto1),
      .mem_we(we1), .mem_addr(addr1), .mem_data(data1), .mem_q(mem_q1),
      .ocupado(ocup1), .fim(fim1), .erro(erro1)
   );

   // Synchronous-read memories; address 5 can be forced to store 2'b01.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= (corrompe && mem_addr == 4'd5) ? 2'b01 : mem_data;
      mem_q <= mem[mem_addr];
      if (we1) mem1 <= data1;
      mem_q1 <= mem1;
   end

   task automatic confere(input string tag, input logic [7:0] obs, input logic [7:0] esp);
      vetores++;
      assert (obs === esp) else begin
         erros++;
         $error("FAIL %s: observado=%0h esperado=%0h", tag, obs, esp);
      end
   endtask

   // One load: model expects the i-th accepted word at address i, fim after the last write
   // (plus N_POS+1 readback cycles when verification is built in).
   task automatic carga(input logic m, input logic ud, input logic [1:0] df, input int padrao,
                        input int rst_em, input int ini_em, input logic corromper);
      int         n_wr = 0, fim_k = -1, n_obs = 0;
      bit         acabou = 1'b0;
      logic       val_v, we_esp, erro_esp;
      logic [1:0] fill_esp, dado_v, data_esp, d5;
      fill_esp = (!m && ud) ? FILL_PADRAO : df;
      d5       = 2'b00;
      erro_esp = 1'b0;
      corrompe = corromper;
      for (int k = 0; k < 100 && !acabou; k++) begin
         @(negedge clk);
         iniciar     = (k == 0) || (fim_k < 0 && n_wr == ini_em);
         modo        = (k == 0) ? m : 1'($urandom);
         usa_default = (k == 0) ? ud : 1'($urandom);
         dado_fill   = (k == 0) ? df : 2'($urandom);
         case (padrao)
            0:       val_v = 1'($urandom);
            1:       val_v = (k % 2 == 1);
            default: val_v = ($urandom_range(0, 2) != 0);
         endcase
         dado_v    = (padrao == 1) ? 2'(n_wr) : 2'($urandom);
         valido_in = val_v;
         dado_in   = dado_v;
         #1;
         we_esp   = (k >= 1) && (n_wr < NP) && (!m || val_v);
         data_esp = m ? dado_v : fill_esp;
         n_obs    = n_obs + int'(mem_we);
         confere("mem_we", 8'(mem_we), 8'(we_esp));
         confere("pronto_in", 8'(pronto_in), 8'((k >= 1) && (n_wr < NP) && m));
         confere("ocupado", 8'(ocupado), 8'((k >= 1) && (fim_k < 0 || k <= fim_k)));
         confere("fim", 8'(fim), 8'(k == fim_k));
         if (k >= 1 && n_wr < NP) confere("mem_addr", 8'(mem_addr), 8'(n_wr));
         if (we_esp) confere("mem_data", 8'(mem_data), 8'(data_esp));
         if (fim_k >= 0 && k > fim_k) confere("addr_idle", 8'(mem_addr), 8'd0);
         if (k == 0) confere("erro_retido", 8'(erro), 8'(erro_ant));
         if (k == 1) confere("erro_limpo", 8'(erro), 8'd0);
         if (fim_k >= 0 && k >= fim_k) confere("erro_fim", 8'(erro), 8'(erro_esp));
         if (rst_em >= 0 && we_esp && n_wr == rst_em) begin
            #1 rst_n = 1'b0;
            #1;
            confere("rst_we", 8'(mem_we), 8'd0);
            confere("rst_ocupado", 8'(ocupado), 8'd0);
            confere("rst_addr", 8'(mem_addr), 8'd0);
            confere("rst_pronto", 8'(pronto_in), 8'd0);
            @(negedge clk);
            rst_n    = 1'b1;
            iniciar  = 1'b0;
            erro_ant = 1'b0;
            return;
         end
         if (we_esp) begin
            if (n_wr == 5) d5 = data_esp;
            n_wr++;
            if (n_wr == NP) begin
               fim_k    = k + 1 + (VERIF ? NP + 1 : 0);
               erro_esp = VERIF && corromper && (d5 != 2'b01);
            end
         end
         if (fim_k >= 0 && k == fim_k + 1) acabou = 1'b1;
      end
      confere("carga_terminou", 8'(acabou), 8'd1);
      confere("total_escritas", 8'(n_obs), 8'(NP));
      erro_ant = erro_esp;
      iniciar  = 1'b0;
   endtask

   task automatic carga_n1();
      int fim_k = 2 + (VERIF ? 2 : 0);
      for (int k = 0; k <= fim_k + 1; k++) begin
         @(negedge clk);
         iniciar1    = (k == 0);
         modo        = (k == 0) ? 1'b0 : 1'($urandom);
         usa_default = (k == 0) ? 1'b1 : 1'($urandom);
         #1;
         confere("n1_we", 8'(we1), 8'(k == 1));
         confere("n1_pronto", 8'(pronto1), 8'd0);
         confere("n1_fim", 8'(fim1), 8'(k == fim_k));
         confere("n1_ocupado", 8'(ocup1), 8'((k >= 1) && (k <= fim_k)));
         if (k == 1) begin
            confere("n1_addr", 8'(addr1), 8'd0);
            confere("n1_data", 8'(data1), 8'(FILL_PADRAO));
         end
         if (k == fim_k) confere("n1_erro", 8'(erro1), 8'd0);
      end
      iniciar1 = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      confere("rst0_we", 8'(mem_we), 8'd0);
      confere("rst0_addr", 8'(mem_addr), 8'd0);
      confere("rst0_data", 8'(mem_data), 8'd0);
      confere("rst0_pronto", 8'(pronto_in), 8'd0);
      confere("rst0_ocupado", 8'(ocupado), 8'd0);
      confere("rst0_fim", 8'(fim), 8'd0);
      confere("rst0_erro", 8'(erro), 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      carga(1'b0, 1'b1, 2'($urandom), 0, -1, -1, 1'b0);  // default fill
      carga(1'b0, 1'b0, 2'($urandom), 0, -1, -1, 1'b0);  // user fill value
      carga(1'b1, 1'b0, 2'b00, 1, -1, -1, 1'b0);         // stream, alternating valid
      carga(1'b0, 1'b0, 2'b11, 0, -1, -1, 1'b1);         // corrupted readback at address 5
      carga(1'b0, 1'b1, 2'b00, 0, -1, -1, 1'b0);         // erro held, then cleared
      carga(1'b0, 1'b1, 2'b00, 0, 7, -1, 1'b0);          // reset at address 7
      carga(1'b0, 1'b1, 2'b00, 0, -1, -1, 1'b0);         // restart from address 0
      carga(1'b0, 1'b1, 2'b00, 0, -1, 3, 1'b0);          // iniciar while busy
      carga(1'b1, 1'b0, 2'b00, 2, -1, 3, 1'b0);
      repeat (4) carga(1'b1, 1'b0, 2'b00, 2, -1, -1, 1'b0);
      carga(1'b0, 1'b0, 2'($urandom), 0, -1, -1, 1'b0);
      carga_n1();

      $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
      $finish;
   end

endmodule
